// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand class indices, exponent limits, canonical NaN, divider states.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents:
//   NORMAL..SNAN, LAST_FLAG : bit positions of the one-hot operand class vector
//   bias/emax/emin          : biased exponent limits as functions of the exponent width
//   canon_qnan              : canonical quiet NaN, right-aligned in 64 bits
//   div_state_t             : iterative divider control states
package fpu_pkg;

  localparam int NORMAL    = 0;
  localparam int SUBNORMAL = 1;
  localparam int ZERO      = 2;
  localparam int INFINITY  = 3;
  localparam int QNAN      = 4;
  localparam int SNAN      = 5;
  localparam int LAST_FLAG = 6;

  function automatic int bias(input int nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  // Largest biased exponent of a finite number (all-ones is reserved).
  function automatic int emax(input int nexp);
    return (1 << nexp) - 2;
  endfunction

  // Smallest biased exponent of a normal number; a format needs at least two
  // exponent bits to have any normals at all.
  function automatic int emin(input int nexp);
    return (nexp >= 2) ? 1 : 0;
  endfunction

  // {0, all-ones exponent, 1, zeros}; callers slice the low NEXP+NSIG+1 bits.
  function automatic logic [63:0] canon_qnan(input int nexp, input int nsig);
    logic [63:0] v;
    v = ((64'd1 << nexp) - 64'd1) << nsig;
    v = v | (64'd1 << (nsig - 1));
    return v;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL,
    DIVIDE,
    NORM,
    DONE
  } div_state_t;

endpackage

// File: rtl/fp_div_iter.sv
// Restoring radix-2 significand divider: one quotient bit per cycle, MSB first.
// Latency: NSIG+3 iteration cycles after load.
// Backpressure: none; load restarts the loop unconditionally.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture dvd_man/dvs_man and start iterating
//   dvd_man, dvs_man  : {1, fraction} of dividend and divisor
//   busy              : more iterations follow the current one
//   q                 : quotient, q[NSIG+2] has weight 2^0
//   rem               : partial remainder (non-zero means the quotient is inexact)
module fp_div_iter #(
  parameter int NSIG = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [NSIG:0]   dvd_man,
  input  logic [NSIG:0]   dvs_man,
  output logic            busy,
  output logic [NSIG+2:0] q,
  output logic [NSIG+1:0] rem
);

  localparam int QW = NSIG + 3;
  localparam int RW = NSIG + 2;
  localparam int CW = $clog2(NSIG + 3);

  logic [RW-1:0] rem_q;
  logic [RW-1:0] div_q;
  logic [QW-1:0] q_q;
  logic [CW-1:0] cnt_q;
  logic          act_q;
  logic          ge;
  logic [RW-1:0] diff;

  assign ge   = (rem_q >= div_q);
  assign diff = ge ? (rem_q - div_q) : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (load) begin
      rem_q <= {1'b0, dvd_man};
      div_q <= {1'b0, dvs_man};
      q_q   <= '0;
      cnt_q <= CW'(NSIG + 2);
      act_q <= 1'b1;
    end else if (act_q) begin
      q_q   <= {q_q[QW-2:0], ge};
      // diff < divisor < 2^(NSIG+1), so the shift never drops a set bit.
      rem_q <= diff << 1;
      if (cnt_q == '0) begin
        act_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Low during the final iteration so the caller can move on with the same
  // edge that retires the last quotient bit.
  assign busy = act_q && (cnt_q != '0);
  assign q    = q_q;
  assign rem  = rem_q;

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 divider a/b (flush-to-zero inputs, truncation; RNE when FPU_DIV_RNE_EN is defined).
// Latency: 1 cycle for NaN/inf/zero operands, NSIG+4 cycles otherwise (27 for binary32).
// Backpressure: accepts only in IDLE; result and flags held in DONE until out_ready.
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start_valid/start_ready, a, b   : operand handshake (dividend a, divisor b)
//   out_valid/out_ready, quo        : result handshake
//   OVERFLOW, UNDERFLOW             : exponent out of range, quo forced to inf / zero
//   DIV_BY_ZERO, INVALID            : x/0 with x non-zero; 0/0, inf/inf or sNaN operand
// Optional feature macro: FPU_DIV_RNE_EN (round-to-nearest-even instead of truncation).
module fp_div_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [NEXP+NSIG:0]   a,
  input  logic [NEXP+NSIG:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   quo,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW,
  output logic                 DIV_BY_ZERO,
  output logic                 INVALID
);

  import fpu_pkg::*;

  localparam int W  = NEXP + NSIG + 1;
  localparam int QW = NSIG + 3;
  localparam int RW = NSIG + 2;
  localparam int EW = NEXP + 2;

  localparam logic [63:0]          QNAN_WIDE = canon_qnan(NEXP, NSIG);
  localparam logic [W-1:0]         QNAN_VAL  = QNAN_WIDE[W-1:0];
  localparam logic [W-1:0]         QUIET_BIT = W'(1) << (NSIG - 1);
  localparam logic signed [EW-1:0] BIAS_E    = EW'(bias(NEXP));
  localparam logic signed [EW-1:0] E_OVF     = EW'(emax(NEXP) + 1);
  localparam logic signed [EW-1:0] E_MIN     = EW'(emin(NEXP));
  localparam logic signed [EW-1:0] ONE_E     = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E    = EW'(0);

  function automatic logic [LAST_FLAG-1:0] classify(input logic [W-2:0] x);
    logic [NEXP-1:0]      e;
    logic [NSIG-1:0]      f;
    logic [LAST_FLAG-1:0] c;
    e = x[W-2:NSIG];
    f = x[NSIG-1:0];
    c = '0;
    if (e == '1) begin
      if (f == '0)           c[INFINITY] = 1'b1;
      else if (f[NSIG-1])    c[QNAN]     = 1'b1;
      else                   c[SNAN]     = 1'b1;
    end else if (e == '0) begin
      if (f == '0)           c[ZERO]      = 1'b1;
      else                   c[SUBNORMAL] = 1'b1;
    end else begin
      c[NORMAL] = 1'b1;
    end
    return c;
  endfunction

  div_state_t st, st_nxt;

  logic [W-1:0]         a_r, b_r;
  logic [LAST_FLAG-1:0] cls_a_r, cls_b_r;
  logic [LAST_FLAG-1:0] cls_in_a, cls_in_b;
  logic                 accept;
  logic                 load;
  logic                 busy;
  logic [QW-1:0]        q;
  logic [RW-1:0]        rem;

  assign cls_in_a = classify(a[W-2:0]);
  assign cls_in_b = classify(b[W-2:0]);

  fp_div_iter #(
    .NSIG (NSIG)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .dvd_man ({1'b1, a[NSIG-1:0]}),
    .dvs_man ({1'b1, b[NSIG-1:0]}),
    .busy    (busy),
    .q       (q),
    .rem     (rem)
  );

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt      = st;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    load        = 1'b0;
    case (st)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept = 1'b1;
          // Subnormals are not NORMAL, so they take the zero path here.
          if (cls_in_a[NORMAL] && cls_in_b[NORMAL]) begin
            load   = 1'b1;
            st_nxt = DIVIDE;
          end else begin
            st_nxt = SPECIAL;
          end
        end
      end
      SPECIAL: st_nxt = DONE;
      DIVIDE:  if (!busy) st_nxt = NORM;
      NORM:    st_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------- special path
  logic         sign_r;
  logic         zero_a, zero_b;
  logic [W-1:0] inf_res, zero_res;
  logic [W-1:0] spec_res;
  logic         spec_inv, spec_dbz;

  assign sign_r   = a_r[W-1] ^ b_r[W-1];
  assign zero_a   = cls_a_r[ZERO] | cls_a_r[SUBNORMAL];
  assign zero_b   = cls_b_r[ZERO] | cls_b_r[SUBNORMAL];
  assign inf_res  = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
  assign zero_res = {sign_r, {(W-1){1'b0}}};

  always_comb begin
    spec_res = zero_res;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (cls_a_r[SNAN]) begin
      spec_res = a_r | QUIET_BIT;
      spec_inv = 1'b1;
    end else if (cls_b_r[SNAN]) begin
      spec_res = b_r | QUIET_BIT;
      spec_inv = 1'b1;
    end else if (cls_a_r[QNAN]) begin
      spec_res = a_r;
    end else if (cls_b_r[QNAN]) begin
      spec_res = b_r;
    end else if ((zero_a && zero_b) || (cls_a_r[INFINITY] && cls_b_r[INFINITY])) begin
      spec_res = QNAN_VAL;
      spec_inv = 1'b1;
    end else if (cls_a_r[INFINITY]) begin
      spec_res = inf_res;
    end else if (cls_a_r[NORMAL] && zero_b) begin
      spec_res = inf_res;
      spec_dbz = 1'b1;
    end else begin
      // 0/x or x/inf
      spec_res = zero_res;
    end
  end

  // ---------------------------------------------------- normalise and round
  logic                 msb;
  logic [NSIG-1:0]      frac_t, frac_r;
  logic signed [EW-1:0] e_div, e_fin;
  logic                 norm_ovf, norm_unf;
  logic [W-1:0]         norm_res;

  // q[QW-1] set means the significand ratio is in [1,2); otherwise it is in
  // [0.5,1) and the next bit down is the leading one.
  assign msb    = q[QW-1];
  assign frac_t = msb ? q[QW-2:2] : q[QW-3:1];

  always_comb begin
    e_div = $signed({2'b00, a_r[W-2:NSIG]}) - $signed({2'b00, b_r[W-2:NSIG]}) + BIAS_E;
    if (!msb) e_div = e_div - ONE_E;
  end

`ifdef FPU_DIV_RNE_EN
  logic            guard, sticky, rnd_up, carry;
  localparam int   FW = NSIG + 1;

  assign guard  = msb ? q[1] : q[0];
  // With a leading one the lowest quotient bit lies below the guard bit.
  assign sticky = (msb & q[0]) | (|rem);
  assign rnd_up = guard & (sticky | frac_t[0]);
  assign {carry, frac_r} = {1'b0, frac_t} + FW'(rnd_up);
  assign e_fin  = e_div + (carry ? ONE_E : ZERO_E);
`else
  logic trunc_unused;

  assign trunc_unused = ^{q[0], rem};
  assign frac_r       = frac_t;
  assign e_fin        = e_div;
`endif

  assign norm_ovf = (e_fin >= E_OVF);
  assign norm_unf = (e_fin <  E_MIN);
  assign norm_res = norm_ovf ? inf_res :
                    norm_unf ? zero_res :
                    {sign_r, e_fin[NEXP-1:0], frac_r};

  // --------------------------------------------------------- state and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      cls_a_r     <= '0;
      cls_b_r     <= '0;
      quo         <= '0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      INVALID     <= 1'b0;
    end else begin
      if (accept) begin
        a_r         <= a;
        b_r         <= b;
        cls_a_r     <= cls_in_a;
        cls_b_r     <= cls_in_b;
        OVERFLOW    <= 1'b0;
        UNDERFLOW   <= 1'b0;
        DIV_BY_ZERO <= 1'b0;
        INVALID     <= 1'b0;
      end
      if (st == SPECIAL) begin
        quo         <= spec_res;
        INVALID     <= spec_inv;
        DIV_BY_ZERO <= spec_dbz;
      end
      if (st == NORM) begin
        quo       <= norm_res;
        OVERFLOW  <= norm_ovf;
        UNDERFLOW <= norm_unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quo;
  logic        OVERFLOW;
  logic        UNDERFLOW;
  logic        DIV_BY_ZERO;
  logic        INVALID;

  int errors = 0;
  int checks = 0;

  fp_div_seq #(.NEXP(8), .NSIG(23)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quo         (quo),
    .OVERFLOW    (OVERFLOW),
    .UNDERFLOW   (UNDERFLOW),
    .DIV_BY_ZERO (DIV_BY_ZERO),
    .INVALID     (INVALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {OVERFLOW, UNDERFLOW, DIV_BY_ZERO, INVALID}.
  function automatic logic [3:0] flags();
    return {OVERFLOW, UNDERFLOW, DIV_BY_ZERO, INVALID};
  endfunction

  // Issue one operation and wait (bounded) for out_valid; lat counts edges
  // after the accept edge, -1 on timeout. The result is left pending.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output logic [31:0] qv, output logic [3:0] fv);
    @(negedge clk);
    a = av;
    b = bv;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (lat < 100 && !out_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    qv = quo;
    fv = flags();
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b want=1", start_ready); end
    checks++; if (quo !== 32'h0) begin errors++; $display("FAIL reset_quo got=%h want=00000000", quo); end
    checks++; if (flags() !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want=0000", flags()); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divide();
    logic [31:0] av [4] = '{32'h40C00000, 32'h3F800000, 32'hC0F00000, 32'h3F800000};
    logic [31:0] bv [4] = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h3FC00000};
    logic [31:0] qe [4];
    int lat;
    logic [31:0] qv;
    logic [3:0] fv;
`ifdef FPU_DIV_RNE_EN
    qe = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h3F2AAAAB};
`else
    qe = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h3F2AAAAA};
`endif
    for (int i = 0; i < 4; i++) begin
      do_op(av[i], bv[i], lat, qv, fv);
      checks++; if (qv !== qe[i]) begin errors++; $display("FAIL div_quo[%0d] got=%h want=%h", i, qv, qe[i]); end
      checks++; if (fv !== 4'b0) begin errors++; $display("FAIL div_flags[%0d] got=%b want=0000", i, fv); end
      checks++; if (lat !== 27) begin errors++; $display("FAIL div_latency[%0d] got=%0d want=27", i, lat); end
      pop();
    end
  endtask

  task automatic test_special();
    logic [31:0] av [9] = '{32'hBF800000, 32'h00000000, 32'h7F800000, 32'h40000000, 32'h7F800001,
                            32'h3F800000, 32'h7F800000, 32'h00000001, 32'h80000000};
    logic [31:0] bv [9] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h7F800000, 32'h3F800000,
                            32'hFFC00005, 32'hFF800000, 32'h3F800000, 32'h40400000};
    logic [31:0] qe [9] = '{32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00001,
                            32'hFFC00005, 32'h7FC00000, 32'h00000000, 32'h80000000};
    logic [3:0]  fe [9] = '{4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
                            4'b0000, 4'b0001, 4'b0000, 4'b0000};
    int lat;
    logic [31:0] qv;
    logic [3:0] fv;
    for (int i = 0; i < 9; i++) begin
      do_op(av[i], bv[i], lat, qv, fv);
      checks++; if (qv !== qe[i]) begin errors++; $display("FAIL spec_quo[%0d] got=%h want=%h", i, qv, qe[i]); end
      checks++; if (fv !== fe[i]) begin errors++; $display("FAIL spec_flags[%0d] got=%b want=%b", i, fv, fe[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL spec_latency[%0d] got=%0d want=1", i, lat); end
      pop();
    end
  endtask

  task automatic test_range();
    int lat;
    logic [31:0] qv;
    logic [3:0] fv;
    do_op(32'h7F000000, 32'h3E800000, lat, qv, fv);
    checks++; if (qv !== 32'h7F800000) begin errors++; $display("FAIL ovf_quo got=%h want=7f800000", qv); end
    checks++; if (fv !== 4'b1000) begin errors++; $display("FAIL ovf_flags got=%b want=1000", fv); end
    pop();
    do_op(32'h00800000, 32'h40000000, lat, qv, fv);
    checks++; if (qv !== 32'h00000000) begin errors++; $display("FAIL unf_quo got=%h want=00000000", qv); end
    checks++; if (fv !== 4'b0100) begin errors++; $display("FAIL unf_flags got=%b want=0100", fv); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] qv;
    logic [3:0] fv;
    do_op(32'h40C00000, 32'h40000000, lat, qv, fv);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || quo !== 32'h40400000 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got valid=%b quo=%h rdy=%b want valid=1 quo=40400000 rdy=0",
                 i, out_valid, quo, start_ready);
      end
    end
    pop();
    // Operands offered while busy must be ignored.
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    a = 32'h40C00000;
    b = 32'h40000000;
    start_valid = 1'b1;
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b want=0", start_ready); end
    @(posedge clk);
    #1;
    lat++;
    start_valid = 1'b0;
    while (lat < 100 && !out_valid) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 27) begin errors++; $display("FAIL busy_latency got=%0d want=27", lat); end
`ifdef FPU_DIV_RNE_EN
    checks++; if (quo !== 32'h3EAAAAAB) begin errors++; $display("FAIL busy_quo got=%h want=3eaaaaab", quo); end
`else
    checks++; if (quo !== 32'h3EAAAAAA) begin errors++; $display("FAIL busy_quo got=%h want=3eaaaaaa", quo); end
`endif
    pop();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] qv;
    logic [3:0] fv;
    do_op(32'h40C00000, 32'h40000000, lat, qv, fv);
    @(negedge clk);
    out_ready = 1'b1;
    start_valid = 1'b1;
    a = 32'hC0F00000;
    b = 32'h40200000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release got valid=%b rdy=%b want valid=0 rdy=1", out_valid, start_ready);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got rdy=%b want=0", start_ready); end
    lat = 0;
    while (lat < 100 && !out_valid) begin @(posedge clk); #1; lat++; end
    checks++; if (quo !== 32'hC0400000) begin errors++; $display("FAIL b2b_quo got=%h want=c0400000", quo); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL b2b_latency got=%0d want=27", lat); end
    pop();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [31:0] qv;
    logic [3:0] fv;
    logic seen;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state got valid=%b rdy=%b want valid=0 rdy=1", out_valid, start_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_output got=%b want=0", seen); end
    do_op(32'h40C00000, 32'h40000000, lat, qv, fv);
    checks++; if (qv !== 32'h40400000) begin errors++; $display("FAIL abort_next_quo got=%h want=40400000", qv); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL abort_next_latency got=%0d want=27", lat); end
    pop();
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_divide();
    test_special();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
